// File: rtl/dot_seq.sv
// dot_seq: sequences operand pairs through an external signed fixed-point
// multiplier (start/done handshake) and accumulates the products into one
// saturated WIDTH-bit dot-product result per vector.
// The accumulator carries G guard bits so that MAX_TERMS full-scale products
// can be summed without wrapping. The result is clamped only when it is
// presented on the output.
module dot_seq #(
    parameter int WIDTH     = 16,
    parameter int MAX_TERMS = 16,
    parameter int TIMEOUT   = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [WIDTH-1:0]                   in_a,
    input  logic [WIDTH-1:0]                   in_b,
    input  logic                               in_last,
    output logic                               mul_start,
    output logic [WIDTH-1:0]                   mul_a,
    output logic [WIDTH-1:0]                   mul_b,
    input  logic                               mul_done,
    input  logic                               mul_valid,
    input  logic                               mul_ovf,
    input  logic [WIDTH-1:0]                   mul_val,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WIDTH-1:0]                   out_sum,
    output logic                               out_ovf,
    output logic                               out_err,
    output logic [$clog2(MAX_TERMS+1)-1:0]     out_count
);

    localparam int G  = $clog2(MAX_TERMS) + 1;
    localparam int AW = WIDTH + G;
    localparam int CW = $clog2(MAX_TERMS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    // The accumulator is outside the output range when its top G+1 bits are
    // not all copies of the sign bit.
    function automatic logic f_sat_hit(input logic [AW-1:0] acc);
        logic [AW-WIDTH:0] top;
        top       = acc[AW-1:WIDTH-1];
        f_sat_hit = !((&top) || (~|top));
    endfunction

    // Clamp the accumulator to the signed WIDTH-bit range.
    function automatic logic [WIDTH-1:0] f_clamp(input logic [AW-1:0] acc);
        if (f_sat_hit(acc)) begin
            if (acc[AW-1]) begin
                f_clamp = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                f_clamp = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end else begin
            f_clamp = acc[WIDTH-1:0];
        end
    endfunction

    state_t             r_state;
    logic               r_in_ready;
    logic               r_mul_start;
    logic [WIDTH-1:0]   r_mul_a;
    logic [WIDTH-1:0]   r_mul_b;
    logic               r_last;
    logic [AW-1:0]      r_acc;
    logic [CW-1:0]      r_count;
    logic               r_ovf_sticky;
    logic               r_err_sticky;
    logic [TW-1:0]      r_tmo;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_sum;
    logic               r_out_ovf;
    logic               r_out_err;
    logic [CW-1:0]      r_out_count;

    state_t             w_state_nxt;
    logic               w_in_ready_nxt;
    logic               w_mul_start_nxt;
    logic [WIDTH-1:0]   w_mul_a_nxt;
    logic [WIDTH-1:0]   w_mul_b_nxt;
    logic               w_last_nxt;
    logic [AW-1:0]      w_acc_nxt;
    logic [CW-1:0]      w_count_nxt;
    logic               w_ovf_nxt;
    logic               w_err_nxt;
    logic [TW-1:0]      w_tmo_nxt;
    logic               w_out_valid_nxt;
    logic [WIDTH-1:0]   w_out_sum_nxt;
    logic               w_out_ovf_nxt;
    logic               w_out_err_nxt;
    logic [CW-1:0]      w_out_count_nxt;
    logic               w_finish;

    logic [AW-1:0]      w_prod_ext;
    logic [AW-1:0]      w_acc_sum;
    logic [CW-1:0]      w_count_inc;

    assign w_prod_ext  = {{G{mul_val[WIDTH-1]}}, mul_val};
    assign w_acc_sum   = r_acc + w_prod_ext;
    assign w_count_inc = (r_count == CW'(MAX_TERMS)) ? r_count : (r_count + CW'(1));

    assign in_ready  = r_in_ready;
    assign mul_start = r_mul_start;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_ovf   = r_out_ovf;
    assign out_err   = r_out_err;
    assign out_count = r_out_count;

    // Next-state and next-register values for the sequencer.
    always_comb begin
        w_state_nxt     = r_state;
        w_in_ready_nxt  = r_in_ready;
        w_mul_start_nxt = 1'b0;
        w_mul_a_nxt     = r_mul_a;
        w_mul_b_nxt     = r_mul_b;
        w_last_nxt      = r_last;
        w_acc_nxt       = r_acc;
        w_count_nxt     = r_count;
        w_ovf_nxt       = r_ovf_sticky;
        w_err_nxt       = r_err_sticky;
        w_tmo_nxt       = r_tmo;
        w_out_valid_nxt = r_out_valid;
        w_out_sum_nxt   = r_out_sum;
        w_out_ovf_nxt   = r_out_ovf;
        w_out_err_nxt   = r_out_err;
        w_out_count_nxt = r_out_count;
        w_finish        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (in_valid && r_in_ready) begin
                    // Force the vector closed once the term budget is used up.
                    w_mul_a_nxt     = in_a;
                    w_mul_b_nxt     = in_b;
                    w_last_nxt      = in_last || (r_count >= CW'(MAX_TERMS - 1));
                    w_mul_start_nxt = 1'b1;
                    w_in_ready_nxt  = 1'b0;
                    w_state_nxt     = S_START;
                end else begin
                    w_in_ready_nxt  = 1'b1;
                end
            end
            S_START: begin
                w_tmo_nxt   = {TW{1'b0}};
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving on the final timeout cycle still wins.
                if (mul_done) begin
                    w_acc_nxt   = w_acc_sum;
                    w_count_nxt = w_count_inc;
                    w_ovf_nxt   = r_ovf_sticky | mul_ovf | ~mul_valid;
                    if (r_last) begin
                        w_finish    = 1'b1;
                        w_state_nxt = S_OUT;
                    end else begin
                        w_in_ready_nxt = 1'b1;
                        w_state_nxt    = S_IDLE;
                    end
                end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                    w_err_nxt   = 1'b1;
                    w_finish    = 1'b1;
                    w_state_nxt = S_OUT;
                end else begin
                    w_tmo_nxt = r_tmo + TW'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    w_acc_nxt       = {AW{1'b0}};
                    w_count_nxt     = {CW{1'b0}};
                    w_ovf_nxt       = 1'b0;
                    w_err_nxt       = 1'b0;
                    w_out_valid_nxt = 1'b0;
                    w_in_ready_nxt  = 1'b1;
                    w_state_nxt     = S_IDLE;
                end else begin
                    w_out_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_in_ready_nxt  = 1'b1;
                w_out_valid_nxt = 1'b0;
                w_state_nxt     = S_IDLE;
            end
        endcase

        // Result is captured from the post-update accumulator and flags so
        // out_valid rises on the same edge as the final accumulation.
        if (w_finish) begin
            w_out_valid_nxt = 1'b1;
            w_out_sum_nxt   = f_clamp(w_acc_nxt);
            w_out_ovf_nxt   = w_ovf_nxt | f_sat_hit(w_acc_nxt);
            w_out_err_nxt   = w_err_nxt;
            w_out_count_nxt = w_count_nxt;
        end else begin
            w_out_sum_nxt   = w_out_sum_nxt;
        end
    end

    // State and datapath registers; synchronous reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_in_ready   <= 1'b1;
            r_mul_start  <= 1'b0;
            r_mul_a      <= {WIDTH{1'b0}};
            r_mul_b      <= {WIDTH{1'b0}};
            r_last       <= 1'b0;
            r_acc        <= {AW{1'b0}};
            r_count      <= {CW{1'b0}};
            r_ovf_sticky <= 1'b0;
            r_err_sticky <= 1'b0;
            r_tmo        <= {TW{1'b0}};
            r_out_valid  <= 1'b0;
            r_out_sum    <= {WIDTH{1'b0}};
            r_out_ovf    <= 1'b0;
            r_out_err    <= 1'b0;
            r_out_count  <= {CW{1'b0}};
        end else begin
            r_state      <= w_state_nxt;
            r_in_ready   <= w_in_ready_nxt;
            r_mul_start  <= w_mul_start_nxt;
            r_mul_a      <= w_mul_a_nxt;
            r_mul_b      <= w_mul_b_nxt;
            r_last       <= w_last_nxt;
            r_acc        <= w_acc_nxt;
            r_count      <= w_count_nxt;
            r_ovf_sticky <= w_ovf_nxt;
            r_err_sticky <= w_err_nxt;
            r_tmo        <= w_tmo_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_out_sum    <= w_out_sum_nxt;
            r_out_ovf    <= w_out_ovf_nxt;
            r_out_err    <= w_out_err_nxt;
            r_out_count  <= w_out_count_nxt;
        end
    end

endmodule
